ub_input_loader: RTL and testbench

//  Reader on the unified-buffer load path: issues one load_input/addr request, captures the 2x2

---
 rtl/tpu_pkg.sv | 27 ++
 rtl/row_skew.sv | 76 +++++++
 rtl/ub_input_loader.sv | 95 +++++++++
 tb/tb_ub_input_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared constants and state encoding for the unified-buffer input load path.
package tpu_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 13;
    localparam int unsigned UB_DEPTH = 64;

    // Highest legal tile base: the tile occupies base..base+3.
    localparam logic [ADDR_W-1:0] MAX_TILE_BASE = ADDR_W'(UB_DEPTH - 4);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        FEED1,
        FEED2,
        FEED3
    } ld_state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_1,
        PH_2,
        PH_3
    } skew_phase_t;

endpackage

// File: rtl/row_skew.sv
// Captures a 2x2 tile on 'go' and emits it diagonally skewed across two rows;
// idle slots always carry zero data.
module row_skew
    import tpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic [DATA_W-1:0] ub_in_00,
    input  logic [DATA_W-1:0] ub_in_01,
    input  logic [DATA_W-1:0] ub_in_10,
    input  logic [DATA_W-1:0] ub_in_11,
    output logic [DATA_W-1:0] a_in1,
    output logic [DATA_W-1:0] a_in2,
    output logic              a_valid1,
    output logic              a_valid2
);

    skew_phase_t       phase;
    logic [DATA_W-1:0] tile_01;
    logic [DATA_W-1:0] tile_10;
    logic [DATA_W-1:0] tile_11;

    // Word 00 goes straight out on the capture edge, so only the later words are held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase    <= PH_IDLE;
            tile_01  <= '0;
            tile_10  <= '0;
            tile_11  <= '0;
            a_in1    <= '0;
            a_in2    <= '0;
            a_valid1 <= 1'b0;
            a_valid2 <= 1'b0;
        end else if (go) begin
            tile_01  <= ub_in_01;
            tile_10  <= ub_in_10;
            tile_11  <= ub_in_11;
            a_in1    <= ub_in_00;
            a_valid1 <= 1'b1;
            a_in2    <= '0;
            a_valid2 <= 1'b0;
            phase    <= PH_1;
        end else begin
            case (phase)
                PH_1: begin
                    a_in1    <= tile_01;
                    a_valid1 <= 1'b1;
                    a_in2    <= tile_10;
                    a_valid2 <= 1'b1;
                    phase    <= PH_2;
                end
                PH_2: begin
                    a_in1    <= '0;
                    a_valid1 <= 1'b0;
                    a_in2    <= tile_11;
                    a_valid2 <= 1'b1;
                    phase    <= PH_3;
                end
                PH_3: begin
                    a_in2    <= '0;
                    a_valid2 <= 1'b0;
                    phase    <= PH_IDLE;
                end
                default: begin
                    a_in1    <= '0;
                    a_in2    <= '0;
                    a_valid1 <= 1'b0;
                    a_valid2 <= 1'b0;
                    phase    <= PH_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/ub_input_loader.sv
// Loads one 2x2 activation tile from the unified buffer and feeds it skewed
// into the two left-edge rows of the systolic array.
module ub_input_loader
    import tpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              ub_load_input,
    output logic [ADDR_W-1:0] ub_addr,
    input  logic [DATA_W-1:0] ub_in_00,
    input  logic [DATA_W-1:0] ub_in_01,
    input  logic [DATA_W-1:0] ub_in_10,
    input  logic [DATA_W-1:0] ub_in_11,
    output logic [DATA_W-1:0] a_in1,
    output logic [DATA_W-1:0] a_in2,
    output logic              a_valid1,
    output logic              a_valid2,
    output logic              busy,
    output logic              done,
    output logic              err
);

    ld_state_t state;
    logic      go_c;
    logic      base_ok_c;

    assign base_ok_c = (base_addr <= MAX_TILE_BASE);

    // UB data is valid during WAIT; the skewer captures it on the edge leaving WAIT.
    assign go_c = (state == WAIT);

    // Load sequencer: range check, one-cycle UB request, then track the feed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ub_load_input <= 1'b0;
            ub_addr       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (start) begin
                        if (base_ok_c) begin
                            ub_load_input <= 1'b1;
                            ub_addr       <= base_addr;
                            busy          <= 1'b1;
                            state         <= REQ;
                        end else begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    ub_load_input <= 1'b0;
                    state         <= WAIT;
                end
                WAIT:  state <= FEED1;
                FEED1: state <= FEED2;
                FEED2: state <= FEED3;
                FEED3: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    ub_load_input <= 1'b0;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

    row_skew u_row_skew (
        .clk      (clk),
        .reset    (reset),
        .go       (go_c),
        .ub_in_00 (ub_in_00),
        .ub_in_01 (ub_in_01),
        .ub_in_10 (ub_in_10),
        .ub_in_11 (ub_in_11),
        .a_in1    (a_in1),
        .a_in2    (a_in2),
        .a_valid1 (a_valid1),
        .a_valid2 (a_valid2)
    );

endmodule

// File: tb/tb_ub_input_loader.sv
// Directed bench for ub_input_loader with a behavioural unified buffer and a feed scoreboard.
module tb_ub_input_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [12:0] base_addr;
    logic        ub_load_input;
    logic [12:0] ub_addr;
    logic [31:0] ub_in_00, ub_in_01, ub_in_10, ub_in_11;
    logic [31:0] a_in1, a_in2;
    logic        a_valid1, a_valid2;
    logic        busy, done, err;

    int errors = 0;
    int checks = 0;
    int req_count = 0;
    int done_count = 0;
    logic force_dead = 1'b0;

    logic [31:0] q1[$];
    logic [31:0] q2[$];
    logic [31:0] mon_exp;

    logic [31:0] mem [0:63];
    logic [31:0] ub_q [0:3];

    always #5 clk = ~clk;

    ub_input_loader dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .ub_load_input (ub_load_input),
        .ub_addr       (ub_addr),
        .ub_in_00      (ub_in_00),
        .ub_in_01      (ub_in_01),
        .ub_in_10      (ub_in_10),
        .ub_in_11      (ub_in_11),
        .a_in1         (a_in1),
        .a_in2         (a_in2),
        .a_valid1      (a_valid1),
        .a_valid2      (a_valid2),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    // Reference buffer contents, independent of the memory model below.
    function automatic logic [31:0] golden(input int a);
        case (a)
            30:      golden = 32'h11;
            31:      golden = 32'h12;
            32:      golden = 32'h21;
            33:      golden = 32'h22;
            default: golden = 32'h1000 + 32'(a);
        endcase
    endfunction

    // Behavioural unified buffer: read registered on the load_input edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h1000 + 32'(i);
            mem[30] <= 32'h11;
            mem[31] <= 32'h12;
            mem[32] <= 32'h21;
            mem[33] <= 32'h22;
            for (int k = 0; k < 4; k++) ub_q[k] <= '0;
        end else if (ub_load_input) begin
            for (int k = 0; k < 4; k++) ub_q[k] <= mem[int'(ub_addr) + k];
        end
    end

    assign ub_in_00 = force_dead ? 32'hDEAD : ub_q[0];
    assign ub_in_01 = force_dead ? 32'hDEAD : ub_q[1];
    assign ub_in_10 = force_dead ? 32'hDEAD : ub_q[2];
    assign ub_in_11 = force_dead ? 32'hDEAD : ub_q[3];

    always @(posedge clk) begin
        if (!reset && ub_load_input) req_count++;
        if (!reset && done) done_count++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop expected feed words when the DUT marks a slot valid; idle slots must be 0.
    always @(negedge clk) begin
        if (a_valid1 === 1'b1) begin
            if (q1.size() == 0) chk("row1_unexpected_valid", 32'(a_valid1), 32'd0);
            else begin
                mon_exp = q1.pop_front();
                chk("row1_data", a_in1, mon_exp);
            end
        end else begin
            chk("row1_idle_zero", a_in1, 32'd0);
        end
        if (a_valid2 === 1'b1) begin
            if (q2.size() == 0) chk("row2_unexpected_valid", 32'(a_valid2), 32'd0);
            else begin
                mon_exp = q2.pop_front();
                chk("row2_data", a_in2, mon_exp);
            end
        end else begin
            chk("row2_idle_zero", a_in2, 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tile(input int base);
        q1.push_back(golden(base));
        q1.push_back(golden(base + 1));
        q2.push_back(golden(base + 2));
        q2.push_back(golden(base + 3));
    endtask

    // One accepted load, checked cycle by cycle from E0 to E6.
    task automatic run_tile(input int base, input logic extra_starts, input logic dead);
        int reqs0;
        int dones0;
        reqs0  = req_count;
        dones0 = done_count;
        start     = 1'b1;
        base_addr = 13'(base);
        push_tile(base);
        step();                                   // E0
        start = extra_starts;
        chk("e0_load", 32'(ub_load_input), 32'd1);
        chk("e0_addr", 32'(ub_addr), 32'(base));
        chk("e0_busy", 32'(busy), 32'd1);
        step();                                   // E1
        start = 1'b0;
        chk("e1_load", 32'(ub_load_input), 32'd0);
        chk("e1_valid1", 32'(a_valid1), 32'd0);
        step();                                   // E2
        if (dead) force_dead = 1'b1;
        start = extra_starts;
        chk("e2_valid1", 32'(a_valid1), 32'd1);
        chk("e2_valid2", 32'(a_valid2), 32'd0);
        step();                                   // E3
        start = 1'b0;
        chk("e3_valid1", 32'(a_valid1), 32'd1);
        chk("e3_valid2", 32'(a_valid2), 32'd1);
        step();                                   // E4
        chk("e4_valid1", 32'(a_valid1), 32'd0);
        chk("e4_valid2", 32'(a_valid2), 32'd1);
        chk("e4_done", 32'(done), 32'd0);
        step();                                   // E5
        chk("e5_valid2", 32'(a_valid2), 32'd0);
        chk("e5_done", 32'(done), 32'd1);
        chk("e5_err", 32'(err), 32'd0);
        chk("e5_busy", 32'(busy), 32'd0);
        step();                                   // E6
        chk("e6_done", 32'(done), 32'd0);
        chk("e6_load", 32'(ub_load_input), 32'd0);
        chk("queue1_drained", 32'(q1.size()), 32'd0);
        chk("queue2_drained", 32'(q2.size()), 32'd0);
        chk("one_ub_request", 32'(req_count - reqs0), 32'd1);
        chk("one_done", 32'(done_count - dones0), 32'd1);
        force_dead = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int reqs0;
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        #1;
        chk("rst_load", 32'(ub_load_input), 32'd0);
        chk("rst_addr", 32'(ub_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_a_in1", a_in1, 32'd0);
        chk("rst_valid2", 32'(a_valid2), 32'd0);
        step();
        step();
        reset = 1'b0;
        step();

        // Basic tile load
        run_tile(30, 1'b0, 1'b0);

        // Starts while busy are ignored
        run_tile(30, 1'b1, 1'b0);

        // Out-of-range base
        reqs0     = req_count;
        start     = 1'b1;
        base_addr = 13'd61;
        step();
        start = 1'b0;
        chk("oor_done", 32'(done), 32'd1);
        chk("oor_err", 32'(err), 32'd1);
        chk("oor_busy", 32'(busy), 32'd0);
        chk("oor_load", 32'(ub_load_input), 32'd0);
        step();
        chk("oor_done_clear", 32'(done), 32'd0);
        chk("oor_err_clear", 32'(err), 32'd0);
        chk("oor_no_request", 32'(req_count - reqs0), 32'd0);

        // Highest legal base
        run_tile(60, 1'b0, 1'b0);

        // Reset during FEED1 aborts immediately
        start     = 1'b1;
        base_addr = 13'd30;
        step();
        start = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
        q1.delete();
        q2.delete();
        chk("abort_valid1", 32'(a_valid1), 32'd0);
        chk("abort_a_in1", a_in1, 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        step();
        reset = 1'b0;
        step();
        run_tile(30, 1'b0, 1'b0);

        // Back-to-back: start held, second load accepted in the done cycle
        start     = 1'b1;
        base_addr = 13'd30;
        push_tile(30);
        push_tile(60);
        step();                                   // E0
        base_addr = 13'd60;
        for (int i = 1; i <= 5; i++) step();      // E5
        chk("b2b_first_done", 32'(done), 32'd1);
        step();                                   // E6
        start = 1'b0;
        chk("b2b_accept_load", 32'(ub_load_input), 32'd1);
        chk("b2b_accept_addr", 32'(ub_addr), 32'd60);
        chk("b2b_done_clear", 32'(done), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("b2b_second_done_timing", 32'(done), (i == 5) ? 32'd1 : 32'd0);
        end
        step();
        chk("b2b_queue1_drained", 32'(q1.size()), 32'd0);
        chk("b2b_queue2_drained", 32'(q2.size()), 32'd0);

        // UB data changing after capture has no effect
        run_tile(30, 1'b0, 1'b1);

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
